// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_access_ctrl
// Description : Sequences one register-file access per request.
//               The sequence is: read two source registers, capture the
//               operands, hand them to an execution unit, wait for its
//               result, optionally write the result back, then pulse DONE.
// Ports       : CLK, RST (async, active-low)
//               REQ_VALID/REQ_READY, REQ_RS1/RS2/RD, REQ_WB  - request side
//               OP_VALID, OPND1/OPND2, RES_VALID, RES_DATA   - execution unit
//               DONE                                         - completion
//               READ/WRITE, ADDR_R1/R2/W, DATA_W, DATA_R1/R2 - register file
// Config      : `define RF_ZERO_REG_EN to hardwire register 0 to zero.
//               In that build, source 0 reads as 0, and a write-back to
//               register 0 is skipped.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_access_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [4:0]  REQ_RS1,
  input  logic [4:0]  REQ_RS2,
  input  logic [4:0]  REQ_RD,
  input  logic        REQ_WB,
  output logic        OP_VALID,
  output logic [31:0] OPND1,
  output logic [31:0] OPND2,
  input  logic        RES_VALID,
  input  logic [31:0] RES_DATA,
  output logic        DONE,
  output logic        READ,
  output logic        WRITE,
  output logic [4:0]  ADDR_R1,
  output logic [4:0]  ADDR_R2,
  output logic [4:0]  ADDR_W,
  output logic [31:0] DATA_W,
  input  logic [31:0] DATA_R1,
  input  logic [31:0] DATA_R2
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_EXE  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DN   = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic        r_wb;
  logic [31:0] r_res;
  logic [31:0] r_opnd1;
  logic [31:0] r_opnd2;
  logic        w_skip_wb;
  logic [31:0] w_cap1;
  logic [31:0] w_cap2;

`ifdef RF_ZERO_REG_EN
  // Register 0 is constant zero: reads ignore the bus, writes are dropped.
  assign w_skip_wb = (r_rd == 5'd0);
  assign w_cap1    = (r_rs1 == 5'd0) ? 32'd0 : DATA_R1;
  assign w_cap2    = (r_rs2 == 5'd0) ? 32'd0 : DATA_R2;
`else
  assign w_skip_wb = 1'b0;
  assign w_cap1    = DATA_R1;
  assign w_cap2    = DATA_R2;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (REQ_VALID) w_next = S_RD;
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_EXE;
      S_EXE:  if (RES_VALID) w_next = (r_wb && !w_skip_wb) ? S_WB : S_DN;
      S_WB:   w_next = S_DN;
      S_DN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; READ and WRITE come from disjoint states so they can
  // never be asserted together.
  always_comb begin
    REQ_READY = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    OP_VALID  = 1'b0;
    DONE      = 1'b0;
    case (r_state)
      S_IDLE: REQ_READY = 1'b1;
      S_RD:   READ      = 1'b1;
      S_CAP:  READ      = 1'b1;
      S_EXE:  OP_VALID  = 1'b1;
      S_WB:   WRITE     = 1'b1;
      S_DN:   DONE      = 1'b1;
      default: REQ_READY = 1'b0;
    endcase
  end

  // Request fields, operands and result. Operands are loaded only in CAP,
  // so they stay stable through EXE and until the next operation's CAP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_rd    <= 5'd0;
      r_wb    <= 1'b0;
      r_res   <= 32'd0;
      r_opnd1 <= 32'd0;
      r_opnd2 <= 32'd0;
    end else begin
      if (r_state == S_IDLE && REQ_VALID) begin
        r_rs1 <= REQ_RS1;
        r_rs2 <= REQ_RS2;
        r_rd  <= REQ_RD;
        r_wb  <= REQ_WB;
      end
      if (r_state == S_CAP) begin
        r_opnd1 <= w_cap1;
        r_opnd2 <= w_cap2;
      end
      if (r_state == S_EXE && RES_VALID) r_res <= RES_DATA;
    end
  end

  assign ADDR_R1 = r_rs1;
  assign ADDR_R2 = r_rs2;
  assign ADDR_W  = r_rd;
  assign DATA_W  = r_res;
  assign OPND1   = r_opnd1;
  assign OPND2   = r_opnd2;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_access_ctrl
// Description : Scoreboard bench for rf_access_ctrl. Includes a register-file
//               model, an execution-unit driver and a reference register
//               array. Honours RF_ZERO_REG_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [4:0]  REQ_RS1 = 5'd0, REQ_RS2 = 5'd0, REQ_RD = 5'd0;
  logic        REQ_WB = 1'b0;
  logic        OP_VALID;
  logic [31:0] OPND1, OPND2;
  logic        RES_VALID = 1'b0;
  logic [31:0] RES_DATA = 32'd0;
  logic        DONE, READ, WRITE;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W;
  logic [31:0] DATA_W, DATA_R1, DATA_R2;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  rf_access_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_RD(REQ_RD), .REQ_WB(REQ_WB),
    .OP_VALID(OP_VALID), .OPND1(OPND1), .OPND2(OPND2),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .DONE(DONE),
    .READ(READ), .WRITE(WRITE), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_R1(DATA_R1), .DATA_R2(DATA_R2)
  );

  always #5 CLK = ~CLK;

  // Register-file model: samples on a read cycle, writes on a write cycle.
  // When not reading, the bus carries junk rather than a usable value.
  logic [31:0] rf_mem [32];
  logic [31:0] init_mem [32];
  logic        init_req = 1'b0;
  logic [31:0] rf_q1 = 32'd0, rf_q2 = 32'd0;

  always @(posedge CLK) begin
    if (init_req) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_mem[i];
    end else if (WRITE) begin
      rf_mem[ADDR_W] <= DATA_W;
    end
    if (READ && !WRITE) begin
      rf_q1 <= rf_mem[ADDR_R1];
      rf_q2 <= rf_mem[ADDR_R2];
    end
  end
  assign DATA_R1 = (READ && !WRITE) ? rf_q1 : ~rf_q1;
  assign DATA_R2 = (READ && !WRITE) ? rf_q2 : ~rf_q2;

  // Reference model and scoreboard
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] res;
    bit          wr;
    int          dly;
  } txn_t;

  logic [31:0] exp_mem [32];
  txn_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rst_ctrl", {28'd0, READ, WRITE, OP_VALID, DONE}, 32'd0);
    chk("rst_opnd", OPND1 | OPND2, 32'd0);
    chk("rst_addr", {17'd0, ADDR_R1, ADDR_R2, ADDR_W}, 32'd0);
    chk("rst_dataw", DATA_W, 32'd0);
  endtask

  // Monitor: pops the expected transaction on acceptance and checks every
  // observable effect against it.
  initial begin
    txn_t cur;
    bit   in_flight = 0;
    bit   prev_op = 0;
    bit   both = 0;
    int   cyc = 0, acc_cyc = 0, op_cnt = 0, wr_cnt = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST) begin
        in_flight = 0;
        prev_op   = 0;
      end else begin
        if (REQ_VALID && REQ_READY) begin
          if (exp_q.size() == 0) chk("unexpected_accept", 32'd1, 32'd0);
          else begin
            cur       = exp_q.pop_front();
            in_flight = 1;
            acc_cyc   = cyc;
            op_cnt    = 0;
            wr_cnt    = 0;
            both      = 0;
          end
        end
        if (READ && WRITE) both = 1;
        if (OP_VALID && in_flight) begin
          if (!prev_op) begin
            chk("opnd1", OPND1, cur.e1);
            chk("opnd2", OPND2, cur.e2);
          end
          op_cnt++;
        end
        prev_op = OP_VALID;
        if (WRITE) begin
          wr_cnt++;
          chk("addr_w", {27'd0, ADDR_W}, {27'd0, cur.rd});
          chk("data_w", DATA_W, cur.res);
        end
        if (DONE) begin
          if (!in_flight) chk("done_no_txn", 32'd1, 32'd0);
          else begin
            chk("latency", cyc - acc_cyc, 4 + cur.dly + (cur.wr ? 1 : 0));
            chk("write_pulses", wr_cnt, cur.wr ? 1 : 0);
            chk("op_valid_cycles", op_cnt, cur.dly + 1);
            chk("opnd1_held", OPND1, cur.e1);
            chk("read_write_excl", {31'd0, both}, 32'd0);
            if (cur.wr) exp_mem[cur.rd] = cur.res;
            done_cnt++;
            in_flight = 0;
          end
        end
      end
    end
  end

  // abort: 0 = complete normally, 1 = reset in EXE, 2 = reset in WB
  task automatic do_op(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit wb,
                       input logic [31:0] res, input int dly,
                       input bit spur, input int abort);
    txn_t t;
    int   n;
    t.rd  = rd;
    t.res = res;
    t.dly = dly;
    t.e1  = (ZERO_EN && rs1 == 5'd0) ? 32'd0 : exp_mem[rs1];
    t.e2  = (ZERO_EN && rs2 == 5'd0) ? 32'd0 : exp_mem[rs2];
    t.wr  = wb && !(ZERO_EN && rd == 5'd0);
    exp_q.push_back(t);
    if (abort == 0) exp_done++;
    REQ_VALID = 1'b1;
    REQ_RS1 = rs1; REQ_RS2 = rs2; REQ_RD = rd; REQ_WB = wb;
    RES_VALID = 1'($urandom_range(0, 1));
    RES_DATA  = $urandom;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    REQ_RS1 = 5'($urandom); REQ_RS2 = 5'($urandom); REQ_RD = 5'($urandom);
    n = 0;
    while (!OP_VALID && n < 10) begin @(posedge CLK); #1; n++; end
    if (!OP_VALID) begin
      chk("op_valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (abort == 1) begin
      RST = 1'b0; #1;
      check_reset_outputs();
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("ready_after_rst", {31'd0, REQ_READY}, 32'd1);
      return;
    end
    RES_VALID = 1'b0;
    repeat (dly) begin
      @(posedge CLK); #1;
      if (spur) begin
        REQ_VALID = 1'($urandom_range(0, 1));
        REQ_WB    = 1'($urandom_range(0, 1));
      end
    end
    REQ_VALID = 1'b0;
    RES_VALID = 1'b1;
    RES_DATA  = res;
    @(posedge CLK); #1;
    RES_VALID = 1'b0;
    RES_DATA  = $urandom;
    if (abort == 2) begin
      chk("write_before_abort", {31'd0, WRITE}, {31'd0, t.wr});
      RST = 1'b0; #1;
      check_reset_outputs();
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("ready_after_rst", {31'd0, REQ_READY}, 32'd1);
      return;
    end
    n = 0;
    while (!REQ_READY && n < 10) begin @(posedge CLK); #1; n++; end
    if (!REQ_READY) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
    init_mem[3] = 32'h11;
    init_mem[4] = 32'h22;
    init_mem[7] = 32'hA5A5_A5A5;
    init_mem[0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) exp_mem[i] = init_mem[i];
    init_req = 1'b1;
    @(posedge CLK); #1;
    init_req = 1'b0;
    check_reset_outputs();
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Basic write-back, result ready immediately
    do_op(5'd3, 5'd4, 5'd5, 1'b1, 32'h33, 0, 1'b0, 0);
    // No write-back
    do_op(5'd5, 5'd5, 5'd9, 1'b0, 32'hDEAD_0001, 0, 1'b0, 0);
    // Read-before-write on the same register, then read it back
    do_op(5'd7, 5'd4, 5'd7, 1'b1, 32'h1, 0, 1'b0, 0);
    do_op(5'd7, 5'd7, 5'd8, 1'b0, 32'h2, 1, 1'b0, 0);
    // Stalled result with stray requests during EXE
    do_op(5'd3, 5'd5, 5'd10, 1'b1, 32'hCAFE_F00D, 10, 1'b1, 0);
    // Register 0 as source and as destination
    do_op(5'd0, 5'd4, 5'd0, 1'b1, 32'h1234_5678, 0, 1'b0, 0);
    do_op(5'd0, 5'd0, 5'd11, 1'b0, 32'h0, 0, 1'b0, 0);
    // Reset mid-EXE, then reset mid-WB and confirm the write never landed
    do_op(5'd3, 5'd4, 5'd12, 1'b1, 32'h7777_7777, 0, 1'b0, 1);
    do_op(5'd3, 5'd4, 5'd13, 1'b1, 32'h8888_8888, 0, 1'b0, 2);
    do_op(5'd13, 5'd12, 5'd14, 1'b0, 32'h0, 0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      do_op(5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 1)), $urandom,
            int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("done_count", done_cnt, exp_done);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
